// File: rtl/deco_binario_7seg.sv
// rtl/deco_binario_7seg.sv - registered hex-to-seven-segment decoder
//
// Purpose: turns a 4-bit value (0x0-0xF) into the segment pattern for one
// seven-segment digit (glyphs 0-9, A, b, C, d, E, F). The pattern is
// registered so the display pins never see decode glitches.
//
// Ports:
//   i_Clk          system clock, rising edge
//   i_Reset        asynchronous active-high reset, forces all segments off
//   Demx_deco_Sel  value to display, unsigned 0-15
//   o_Segmentos    registered segment drive, [6]=a .. [0]=g
//
// SEG_ACTIVE_LOW = 0 drives a lit segment as 1 (common cathode);
// SEG_ACTIVE_LOW = 1 inverts every bit (common anode).

module deco_binario_7seg #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] Demx_deco_Sel,
  output logic [6:0] o_Segmentos
);

  // "All segments off" in the selected polarity.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] seg_hi;   // active-high pattern, a..g
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  // An X/Z select bit matches no case item, so simulation falls through
  // to the default and shows a blank digit.
  always_comb begin
    seg_hi = 7'h00;
    unique case (Demx_deco_Sel)
      4'h0: seg_hi = 7'h7E;
      4'h1: seg_hi = 7'h30;
      4'h2: seg_hi = 7'h6D;
      4'h3: seg_hi = 7'h79;
      4'h4: seg_hi = 7'h33;
      4'h5: seg_hi = 7'h5B;
      4'h6: seg_hi = 7'h5F;
      4'h7: seg_hi = 7'h70;
      4'h8: seg_hi = 7'h7F;
      4'h9: seg_hi = 7'h7B;
      4'hA: seg_hi = 7'h77;
      4'hB: seg_hi = 7'h1F;
      4'hC: seg_hi = 7'h4E;
      4'hD: seg_hi = 7'h3D;
      4'hE: seg_hi = 7'h4F;
      4'hF: seg_hi = 7'h47;
      default: seg_hi = 7'h00;
    endcase
  end

  always_comb begin
    seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      seg_q <= SEG_OFF;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign o_Segmentos = seg_q;

endmodule

// File: tb/tb_deco_binario_7seg.sv
// tb/tb_deco_binario_7seg.sv - self-checking bench for deco_binario_7seg

module tb_deco_binario_7seg;

  logic       clk;
  logic       rst;
  logic [3:0] sel;
  logic [6:0] seg_ch;   // common-cathode instance
  logic [6:0] seg_ca;   // common-anode instance

  int total;
  int bad;

  deco_binario_7seg #(.SEG_ACTIVE_LOW(1'b0)) u_dut_ch (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .Demx_deco_Sel (sel),
    .o_Segmentos   (seg_ch)
  );

  deco_binario_7seg #(.SEG_ACTIVE_LOW(1'b1)) u_dut_ca (
    .i_Clk         (clk),
    .i_Reset       (rst),
    .Demx_deco_Sel (sel),
    .o_Segmentos   (seg_ca)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each glyph spelled as its lit segment letters.
  string glyphs [16] = '{"abcdef", "bc", "abdeg", "abcdg",
                         "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg",
                         "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] ref_seg(input int v);
    string s;
    logic [6:0] r;
    r = '0;
    s = glyphs[v];
    for (int i = 0; i < s.len(); i++) begin
      r[6 - int'(s[i] - "a")] = 1'b1;   // a is bit 6, g is bit 0
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Present v, clock once, and check both polarities just after the edge.
  task automatic step_check(input string tag, input int v);
    sel = 4'(v);
    @(posedge clk);
    #1;
    check_val({tag, "_ch"}, seg_ch, ref_seg(v));
    check_val({tag, "_ca"}, seg_ca, ~ref_seg(v));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    sel   = 4'h8;

    // Reset state.
    #2;
    check_val("rst_ch", seg_ch, 7'h00);
    check_val("rst_ca", seg_ca, 7'h7F);
    @(posedge clk);
    #1;
    check_val("rst_hold_ch", seg_ch, 7'h00);

    // Release with 8 held: first edge loads it.
    #2;
    rst = 1'b0;
    #1;
    check_val("rel_pre_edge", seg_ch, 7'h00);
    @(posedge clk);
    #1;
    check_val("rel_ch", seg_ch, 7'h7F);
    check_val("rel_ca", seg_ca, 7'h00);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_ch", seg_ch, 7'h00);
    check_val("async_rst_ca", seg_ca, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full sweep.
    for (int v = 0; v < 16; v++) step_check($sformatf("sweep%0h", v), v);

    // Hold: glitches between edges must not reach the output.
    sel = 4'h3; #1;
    sel = 4'h5; #1;
    check_val("hold_mid", seg_ch, ref_seg(15));
    sel = 4'h3;
    @(posedge clk);
    #1;
    check_val("hold_edge", seg_ch, 7'h79);
    #2;
    check_val("hold_after", seg_ch, 7'h79);

    // Wrap and repeat.
    step_check("wrapF", 15);
    step_check("wrap0a", 0);
    step_check("wrap0b", 0);
    step_check("wrap1", 1);

    // Mid-stream reset at value 6.
    for (int v = 0; v <= 6; v++) step_check($sformatf("pre_rst%0h", v), v);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_ch", seg_ch, 7'h00);
    check_val("mid_rst_ca", seg_ca, 7'h7F);
    @(posedge clk);
    #1;
    check_val("mid_rst_hold", seg_ch, 7'h00);
    sel = 4'h7;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_rst_resume_ch", seg_ch, 7'h70);
    check_val("mid_rst_resume_ca", seg_ca, 7'h0F);

    // Randomized back-to-back values.
    for (int n = 0; n < 200; n++) begin
      step_check($sformatf("rnd%0d", n), int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
